// File: rtl/pc_sequencer.sv
// Fetch/branch sequencer: walks each instruction through fetch, execute wait and PC update,
// and drives the PC select plus the sign-extended branch word offset.
module pc_sequencer #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CW      = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] instr,
    output logic [31:0] ir,
    output logic        ir_load,
    input  logic        exec_done,
    input  logic        zero,
    output logic [1:0]  PS,
    output logic [63:0] pc_offset,
    output logic        busy,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_HALTED = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        K_OTHER = 2'd0,
        K_B     = 2'd1,
        K_CBZ   = 2'd2,
        K_CBNZ  = 2'd3
    } kind_t;

    localparam logic [31:0]   HLT_WORD  = 32'hD440_0000;
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

    state_t         r_state;
    kind_t          r_kind;
    logic [31:0]    r_ir;
    logic [63:0]    r_pc_offset;
    logic [CW-1:0]  r_wait_cnt;
    logic           r_taken;
    logic           r_ir_load;
    logic           r_imem_req;
    logic           r_busy;
    logic           r_halted;
    logic           r_fault;
    logic [1:0]     r_ps;

    state_t         w_next;
    logic [CW-1:0]  w_cnt_next;
    logic           w_capture;
    logic           w_taken_next;
    logic [1:0]     w_ps_next;

    function automatic kind_t f_kind(input logic [31:0] w);
        kind_t k;
        if (w[31:26] == 6'b000101) begin
            k = K_B;
        end else if (w[31:24] == 8'hB4) begin
            k = K_CBZ;
        end else if (w[31:24] == 8'hB5) begin
            k = K_CBNZ;
        end else begin
            k = K_OTHER;
        end
        return k;
    endfunction

    function automatic logic [63:0] f_offset(input logic [31:0] w);
        logic [63:0] o;
        case (f_kind(w))
            K_B:          o = {{38{w[25]}}, w[25:0]};
            K_CBZ, K_CBNZ: o = {{45{w[23]}}, w[23:5]};
            default:      o = 64'd0;
        endcase
        return o;
    endfunction

    // Next-state, fetch-timeout counter and branch decision
    always_comb begin
        w_next       = r_state;
        w_cnt_next   = r_wait_cnt;
        w_capture    = 1'b0;
        w_taken_next = r_taken;
        case (r_state)
            ST_IDLE: begin
                if (run) begin
                    w_next = ST_FETCH;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_FETCH: begin
                // An ack on the final allowed cycle still wins over the timeout
                if (imem_ack) begin
                    w_capture  = 1'b1;
                    w_cnt_next = {CW{1'b0}};
                    if (instr == HLT_WORD) begin
                        w_next = ST_HALTED;
                    end else begin
                        w_next = ST_EXEC;
                    end
                end else if (r_wait_cnt == TIMEOUT_C) begin
                    w_next = ST_FAULT;
                end else begin
                    w_cnt_next = r_wait_cnt + CW'(1);
                end
            end
            ST_EXEC: begin
                if (exec_done) begin
                    w_next = ST_UPDATE;
                    case (r_kind)
                        K_B:     w_taken_next = 1'b1;
                        K_CBZ:   w_taken_next = zero;
                        K_CBNZ:  w_taken_next = ~zero;
                        default: w_taken_next = 1'b0;
                    endcase
                end else begin
                    w_next = ST_EXEC;
                end
            end
            ST_UPDATE: begin
                if (run) begin
                    w_next = ST_FETCH;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_HALTED: w_next = ST_HALTED;
            ST_FAULT:  w_next = ST_FAULT;
            default:   w_next = ST_IDLE;
        endcase
    end

    // PS is pre-decoded for the state being entered so that it is a plain register output
    always_comb begin
        w_ps_next = 2'b00;
        if (w_next == ST_UPDATE) begin
            w_ps_next = w_taken_next ? 2'b11 : 2'b01;
        end else begin
            w_ps_next = 2'b00;
        end
    end

    // State, instruction/decode registers and registered Moore outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_kind      <= K_OTHER;
            r_ir        <= 32'd0;
            r_pc_offset <= 64'd0;
            r_wait_cnt  <= {CW{1'b0}};
            r_taken     <= 1'b0;
            r_ir_load   <= 1'b0;
            r_imem_req  <= 1'b0;
            r_busy      <= 1'b0;
            r_halted    <= 1'b0;
            r_fault     <= 1'b0;
            r_ps        <= 2'b00;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_cnt_next;
            r_taken    <= w_taken_next;
            r_ir_load  <= w_capture;
            if (w_capture) begin
                r_ir        <= instr;
                r_pc_offset <= f_offset(instr);
                r_kind      <= f_kind(instr);
            end
            r_imem_req <= (w_next == ST_FETCH);
            r_busy     <= (w_next == ST_FETCH) || (w_next == ST_EXEC) || (w_next == ST_UPDATE);
            r_halted   <= (w_next == ST_HALTED);
            r_fault    <= (w_next == ST_FAULT);
            r_ps       <= w_ps_next;
        end
    end

    // Reset must stop a PC load even in the middle of an UPDATE cycle
    assign PS        = reset ? r_ps : 2'b00;
    assign imem_req  = r_imem_req;
    assign ir        = r_ir;
    assign ir_load   = r_ir_load;
    assign pc_offset = r_pc_offset;
    assign busy      = r_busy;
    assign halted    = r_halted;
    assign fault     = r_fault;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a behavioural PC plus an instruction-level decode model
// judge directed and randomized instruction streams.
module tb_pc_sequencer;

    localparam int TIMEOUT = 15;
    localparam logic [31:0] HLT = 32'hD440_0000;
    localparam logic [31:0] ADD = 32'h8B02_0020;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [31:0] instr = 32'd0;
    logic [31:0] ir;
    logic        ir_load;
    logic        exec_done = 1'b0;
    logic        zero = 1'b0;
    logic [1:0]  PS;
    logic [63:0] pc_offset;
    logic        busy;
    logic        halted;
    logic        fault;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    logic [63:0] pc_m = 64'd0;
    int load_cnt = 0;
    int ps_cycles = 0;
    int ps10_cnt = 0;

    pc_sequencer #(.TIMEOUT(TIMEOUT), .CW(4)) dut (
        .clock(clock), .reset(reset), .run(run),
        .imem_req(imem_req), .imem_ack(imem_ack), .instr(instr),
        .ir(ir), .ir_load(ir_load), .exec_done(exec_done), .zero(zero),
        .PS(PS), .pc_offset(pc_offset), .busy(busy), .halted(halted), .fault(fault)
    );

    always #5 clock = ~clock;

    // Behavioural 64-bit program counter reacting to PS, plus event counters
    always @(posedge clock) begin
        if (PS == 2'b01) pc_m <= pc_m + 64'd4;
        else if (PS == 2'b11) pc_m <= pc_m + 64'd4 + (pc_offset << 2);
        if (PS == 2'b10) ps10_cnt <= ps10_cnt + 1;
        if (PS != 2'b00) ps_cycles <= ps_cycles + 1;
        if (ir_load) load_cnt <= load_cnt + 1;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Instruction semantics: word offset and branch decision
    task automatic model(input logic [31:0] w, input logic zv, output longint off, output bit tk);
        logic signed [25:0] s26;
        logic signed [18:0] s19;
        s26 = w[25:0];
        s19 = w[23:5];
        if (w[31:26] == 6'b000101) begin
            off = s26; tk = 1'b1;
        end else if (w[31:24] == 8'hB4) begin
            off = s19; tk = zv;
        end else if (w[31:24] == 8'hB5) begin
            off = s19; tk = !zv;
        end else begin
            off = 0; tk = 1'b0;
        end
    endtask

    // Starts in FETCH with a fresh wait counter; ends just after the capturing edge
    task automatic do_fetch(input logic [31:0] w, input int ackd);
        for (int i = 0; i < ackd; i++) begin
            chk("fetch_req", 64'(imem_req), 64'd1);
            chk("fetch_ps", 64'(PS), 64'd0);
            step();
        end
        imem_ack = 1'b1;
        instr = w;
        step();
        imem_ack = 1'b0;
        instr = $urandom;
    endtask

    task automatic run_instr(input logic [31:0] w, input logic zv, input int ackd,
                             input int execd, input bit drop_run);
        logic [63:0] pc0;
        int l0, p0;
        longint off;
        bit tk;
        pc0 = pc_m;
        l0 = load_cnt;
        p0 = ps_cycles;
        model(w, zv, off, tk);
        do_fetch(w, ackd);
        chk("ir", 64'(ir), 64'(w));
        chk("pc_offset", pc_offset, 64'(off));
        chk("no_fault", 64'(fault), 64'd0);
        for (int i = 0; i < execd; i++) begin
            chk("ir_load", 64'(ir_load), (i == 0) ? 64'd1 : 64'd0);
            chk("exec_ps", 64'(PS), 64'd0);
            chk("exec_busy", 64'(busy), 64'd1);
            if (drop_run && i == 0) run = 1'b0;
            step();
        end
        exec_done = 1'b1;
        zero = zv;
        step();
        exec_done = 1'b0;
        zero = 1'($urandom);
        chk("update_ps", 64'(PS), tk ? 64'd3 : 64'd1);
        step();
        chk("pc", pc_m, pc0 + 64'd4 + (tk ? 64'(off * 4) : 64'd0));
        chk("load_once", 64'(load_cnt - l0), 64'd1);
        chk("ps_once", 64'(ps_cycles - p0), 64'd1);
        if (drop_run) begin
            chk("idle_after_drop", 64'(busy), 64'd0);
            step();
            chk("idle_req", 64'(imem_req), 64'd0);
            run = 1'b1;
            step();
        end
        chk("next_fetch", 64'(imem_req), 64'd1);
    endtask

    initial begin
        logic [63:0] pc0;
        int p0;
        logic [31:0] w;

        // Reset held low two cycles
        run = 1'b1;
        step();
        step();
        chk("rst_ir", 64'(ir), 64'd0);
        chk("rst_off", pc_offset, 64'd0);
        chk("rst_outs", 64'({imem_req, ir_load, PS, busy, halted, fault}), 64'd0);
        reset = 1'b1;
        step();
        chk("fetch_busy", 64'(busy), 64'd1);

        // Straight-line and branch instructions
        run_instr(ADD, 1'b0, 2, 3, 1'b0);
        run_instr({6'b000101, 26'h3FF_FFFF}, 1'b0, 1, 1, 1'b0);
        run_instr({8'hB4, 19'd3, 5'd0}, 1'b1, 0, 2, 1'b0);
        run_instr({8'hB4, 19'd3, 5'd0}, 1'b0, 0, 2, 1'b0);
        run_instr({8'hB5, 19'd3, 5'd0}, 1'b1, 1, 1, 1'b0);
        run_instr({8'hB5, 19'd3, 5'd0}, 1'b0, 1, 1, 1'b0);
        run_instr({8'hB4, 19'h40000, 5'd7}, 1'b1, TIMEOUT, 1, 1'b0);

        // Randomized stream, with run dropped mid-instruction now and then
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0: w = {6'b000101, 26'($urandom)};
                1: w = {8'hB4, 24'($urandom)};
                2: w = {8'hB5, 24'($urandom)};
                default: w = $urandom;
            endcase
            if (w == HLT) w = w ^ 32'd1;
            run_instr(w, 1'($urandom), $urandom_range(0, TIMEOUT), $urandom_range(1, 4), (k % 10) == 9);
        end

        // Reset during EXEC abandons the instruction
        pc0 = pc_m;
        p0 = ps_cycles;
        do_fetch({6'b000101, 26'd5}, 1);
        step();
        reset = 1'b0;
        step();
        chk("rst_exec_busy", 64'(busy), 64'd0);
        chk("rst_exec_ir", 64'(ir), 64'd0);
        chk("rst_exec_off", pc_offset, 64'd0);
        chk("rst_exec_pc", pc_m, pc0);
        chk("rst_exec_ps", 64'(ps_cycles - p0), 64'd0);
        reset = 1'b1;
        step();

        // Reset asserted during UPDATE blocks PS at once
        pc0 = pc_m;
        do_fetch(ADD, 0);
        step();
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        chk("upd_ps", 64'(PS), 64'd1);
        reset = 1'b0;
        #1;
        chk("upd_rst_ps", 64'(PS), 64'd0);
        step();
        chk("upd_rst_pc", pc_m, pc0);
        reset = 1'b1;
        step();

        // Fetch timeout
        for (int i = 0; i < TIMEOUT; i++) begin
            chk("to_nofault", 64'(fault), 64'd0);
            step();
        end
        chk("to_edge_nofault", 64'(fault), 64'd0);
        step();
        chk("to_fault", 64'(fault), 64'd1);
        chk("to_outs", 64'({imem_req, PS, busy, halted}), 64'd0);
        for (int i = 0; i < 4; i++) begin
            run = 1'($urandom);
            step();
            chk("fault_sticky", 64'(fault), 64'd1);
        end
        reset = 1'b0;
        step();
        chk("fault_cleared", 64'(fault), 64'd0);
        reset = 1'b1;
        run = 1'b1;
        step();

        // HLT
        pc0 = pc_m;
        p0 = ps_cycles;
        do_fetch(HLT, 1);
        chk("hlt_halted", 64'(halted), 64'd1);
        chk("hlt_ir", 64'(ir), 64'(HLT));
        chk("hlt_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 6; i++) begin
            run = 1'($urandom);
            step();
            chk("hlt_sticky", 64'({halted, imem_req, PS}), 64'b1000);
        end
        chk("hlt_pc", pc_m, pc0);
        chk("hlt_ps", 64'(ps_cycles - p0), 64'd0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        run = 1'b0;
        step();
        chk("hlt_idle", 64'({halted, busy, imem_req}), 64'd0);
        chk("ps10_never", 64'(ps10_cnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
